ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch front end for Tiny86. It is the consumer side of the `next_eip` produced by the control flow unit.
- Accepts a redirect EIP and issues word-aligned memory reads over a valid/ready request channel.
- Buffers returned bytes in a byte prefetch queue and presents up to 15 bytes plus their EIP to the decoder.
- Retires bytes when the decoder reports the consumed instruction length.

Parameters:
- DEPTH, 16, queue capacity in bytes; power of two, at least 16.
- AW, 32, address/EIP width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- redirect_valid  in  1  load new fetch EIP this cycle.
- redirect_eip  in  32  new EIP (driven from `next_eip`).
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned read address; bits [1:0] always 0.
- mem_rsp_valid  in  1  read data returning (exactly one per accepted request, in order).
- mem_rsp_data  in  32  little-endian word; byte 0 = lowest address.
- dec_valid  out  1  at least one byte buffered and not flushing.
- dec_eip  out  32  EIP of `dec_bytes` byte 0.
- dec_bytes  out  120  next 15 queue bytes; byte i at [8i+7:8i]; bytes at or beyond `dec_avail` are 0.
- dec_avail  out  5  valid bytes, min(count, 15).
- dec_consume  in  1  decoder retires one instruction.
- dec_instr_len  in  4  length of retired instruction, 1..15.
- underflow_err  out  1  sticky; set by an illegal consume.

Behaviour:
- Reset (rst_n=0 at a clock edge) drives:
  - state=IDLE, count=0, head/tail=0.
  - dec_eip=0, mem_req_valid=0, underflow_err=0.
  - no outstanding request.
- Reset mid-transaction drops any in-flight response: the memory side is reset by the same rst_n.
- State machine:
  - IDLE: no valid fetch PC. Stays here until redirect_valid=1, then goes to RUN.
  - RUN: fetch_pc holds the next word address to request. Assert mem_req_valid when no request is outstanding and free space (DEPTH-count) is at least 4.
    - Request handshake completes when mem_req_valid & mem_req_ready; fetch_pc += 4.
    - mem_req_valid and mem_req_addr stay stable until accepted. They are dropped only by a redirect.
  - DRAIN: entered on a redirect while a request is outstanding and its response has not arrived this cycle.
    - The next mem_rsp_valid is discarded; then go to RUN.
    - mem_req_valid=0 and dec_valid=0 in DRAIN.
- Redirect, cycle N:
  - Queue flushes (count=0).
  - dec_eip <= redirect_eip.
  - fetch_pc <= redirect_eip & ~3.
  - skip <= redirect_eip[1:0].
  - Earliest new request is visible in cycle N+1.
- Response write: append the 4 bytes minus the `skip` leading bytes (first response after a redirect only), then clear skip. count grows by 4-skip. Tail wraps modulo DEPTH.
- Priority in one cycle: redirect > response > consume. A redirect overrides a same-cycle consume and a same-cycle response.
  - If the response and redirect coincide, that response is dropped and the FSM goes to RUN, not DRAIN.
- Simultaneous response and legal consume: count <= count + added - dec_instr_len. Both the head and tail pointers advance.
- Consume is legal only if dec_valid=1 and dec_instr_len is in 1..dec_avail.
  - Legal: head += len (mod DEPTH), dec_eip += len (32-bit wrap), count -= len.
  - Illegal: no state change; underflow_err <= 1, held until reset.
- Full: no request is issued when free space < 4, so overflow is impossible by construction.
- Empty: dec_valid=0, dec_avail=0.
- EIP wrap: fetch_pc and dec_eip wrap modulo 2^32 without error.
- Latency: redirect at N with single-cycle memory (ready=1, response one cycle after acceptance):
  - request accepted at N+1;
  - data returned at N+2;
  - dec_valid=1 at N+3.

Optional Feature:
- Macro IFETCH_STATS_EN.
- Defined: adds outputs stat_redirects [31:0] (count of redirects) and stat_discards [31:0] (responses dropped in DRAIN or on coincident redirect). Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then redirect 0x1000; memory returns 0x44332211 and then 0x88776655 -> mem_req_addr 0x1000, then 0x1004; dec_eip=0x1000; dec_bytes[31:0]=0x44332211; dec_avail=8.
- Redirect 0x1003; memory returns 0xDDCCBBAA -> dec_avail=1, dec_bytes[7:0]=0xDD, dec_eip=0x1003; next request addr 0x1004.
- Queue holding 8 bytes at dec_eip 0x2000; consume len=3 while a 4-byte response arrives -> count=9, dec_eip=0x2003, no err.
- Redirect 0x3000 while a request to 0x1008 is outstanding and unanswered -> DRAIN; next response discarded; following request addr 0x3000; dec_valid=0 until 0x3000 data arrives.
- mem_req_ready held 0 with queue at 13 bytes -> no request issued (free space 3); consume len=5 -> request issued next cycle.
- dec_avail=2, consume len=4 -> state unchanged, underflow_err=1 and held after a later redirect; cleared only by rst_n=0.

Source files
------------

// File: rtl/ifetch_queue.sv
// Tiny86 instruction fetch queue: word-aligned memory reads feed a byte queue presented to the decoder.
// Optional IFETCH_STATS_EN adds saturating redirect/discard counters.
module ifetch_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_eip,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_rsp_valid,
    input  logic [31:0]   mem_rsp_data,
    output logic          dec_valid,
    output logic [AW-1:0] dec_eip,
    output logic [119:0]  dec_bytes,
    output logic [4:0]    dec_avail,
    input  logic          dec_consume,
    input  logic [3:0]    dec_instr_len,
    output logic          underflow_err
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]   stat_redirects,
    output logic [31:0]   stat_discards
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] fetch_pc;
    logic [1:0]    skip;
    logic          outstanding;
    logic [7:0]    q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [2:0]    add_len;
    logic          req_fire, rsp_take, rsp_write, consume_ok, consume_bad;

    assign free        = CW'(DEPTH) - count;
    assign add_len     = 3'd4 - {1'b0, skip};
    assign req_fire    = mem_req_valid & mem_req_ready;
    assign rsp_take    = outstanding & mem_rsp_valid;
    assign rsp_write   = rsp_take & (state == RUN) & ~redirect_valid;
    assign consume_ok  = dec_valid & dec_consume & ~redirect_valid &
                         (dec_instr_len != 4'd0) & ({1'b0, dec_instr_len} <= dec_avail);
    assign consume_bad = dec_consume & ~redirect_valid & ~consume_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A request accepted in the redirect cycle still owes a response, so it must be drained.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (redirect_valid) state_nx = RUN;
            RUN:   if (redirect_valid)
                       state_nx = (req_fire | (outstanding & ~mem_rsp_valid)) ? DRAIN : RUN;
            DRAIN: if (redirect_valid) state_nx = rsp_take ? RUN : DRAIN;
                   else if (rsp_take)  state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = (state == RUN) & ~outstanding & (free >= CW'(4));
        mem_req_addr  = {fetch_pc[AW-1:2], 2'b00};
        dec_valid     = (state == RUN) & (count != '0);
        dec_avail     = (count > CW'(15)) ? 5'd15 : 5'(count);
        dec_bytes     = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (i < 32'(dec_avail)) dec_bytes[8*i +: 8] = q[head + PW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc      <= '0;
            dec_eip       <= '0;
            skip          <= '0;
            outstanding   <= 1'b0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (consume_bad) underflow_err <= 1'b1;
            if (redirect_valid) begin
                fetch_pc    <= {redirect_eip[AW-1:2], 2'b00};
                dec_eip     <= redirect_eip;
                skip        <= redirect_eip[1:0];
                outstanding <= req_fire | (outstanding & ~mem_rsp_valid);
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (req_fire)      outstanding <= 1'b1;
                else if (rsp_take) outstanding <= 1'b0;
                if (req_fire) fetch_pc <= fetch_pc + AW'(4);
                // skip survives a drained response; only a written response consumes it
                if (rsp_write) begin
                    tail <= tail + PW'(add_len);
                    skip <= '0;
                end
                if (consume_ok) begin
                    head    <= head + PW'(dec_instr_len);
                    dec_eip <= dec_eip + AW'(dec_instr_len);
                end
                count <= count + (rsp_write ? CW'(add_len) : '0)
                               - (consume_ok ? CW'(dec_instr_len) : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_write) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (k >= {30'd0, skip})
                    q[tail + PW'(k) - PW'(skip)] <= mem_rsp_data[8*k +: 8];
            end
        end
    end

`ifdef IFETCH_STATS_EN
    logic discard;
    assign discard = rsp_take & (redirect_valid | (state == DRAIN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_redirects <= '0;
            stat_discards  <= '0;
        end else begin
            if (redirect_valid && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
            if (discard && stat_discards != '1)         stat_discards  <= stat_discards + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed vector table, corner sequences, and
// randomized traffic compared against a byte-queue reference model.
module tb_ifetch_queue;

    localparam int unsigned DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n, redirect_valid, mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0]  redirect_eip, mem_req_addr, mem_rsp_data, dec_eip;
    logic         dec_valid, dec_consume, underflow_err;
    logic [119:0] dec_bytes;
    logic [4:0]   dec_avail;
    logic [3:0]   dec_instr_len;
`ifdef IFETCH_STATS_EN
    logic [31:0]  stat_redirects, stat_discards;
`endif

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_eip(redirect_eip),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dec_valid(dec_valid), .dec_eip(dec_eip), .dec_bytes(dec_bytes), .dec_avail(dec_avail),
        .dec_consume(dec_consume), .dec_instr_len(dec_instr_len), .underflow_err(underflow_err)
`ifdef IFETCH_STATS_EN
        , .stat_redirects(stat_redirects), .stat_discards(stat_discards)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] re, input logic rdy,
                         input logic rv, input logic [31:0] d, input logic c, input logic [3:0] l);
        rst_n = r; redirect_valid = rd; redirect_eip = re; mem_req_ready = rdy;
        mem_rsp_valid = rv; mem_rsp_data = d; dec_consume = c; dec_instr_len = l;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst_n, redir; logic [31:0] reip; logic rdy, rv; logic [31:0] data;
        logic cons; logic [3:0] len;
        logic e_req; logic [31:0] e_addr; logic e_dv; logic [4:0] e_avail;
        logic [31:0] e_eip; logic [31:0] e_b0; logic e_err;
    } vec_t;

    vec_t vt[25];

    // reference model state
    logic [7:0]  mq[$];
    logic [31:0] m_eip, m_pc;
    logic [1:0]  m_skip;
    int          m_mode;      // 0 idle, 1 fetching, 2 draining
    bit          m_out, m_err;
    longint      m_redirs, m_discs;

    function automatic bit model_req();
        return (m_mode == 1) && !m_out && (int'(DEPTH) - mq.size() >= 4);
    endfunction

    task automatic model_reset;
        mq.delete(); m_eip = 0; m_pc = 0; m_skip = 0; m_mode = 0; m_out = 0; m_err = 0;
        m_redirs = 0; m_discs = 0;
    endtask

    task automatic model_step(input bit r, input bit rd, input logic [31:0] re, input bit rdy,
                              input bit rv, input logic [31:0] d, input bit c, input int len);
        bit fire, drain;
        int avail;
        if (!r) begin
            model_reset();
            return;
        end
        fire = model_req() && rdy;
        if (rd) begin
            m_redirs++;
            if (m_out && rv) m_discs++;
            drain  = fire || (m_out && !rv);
            mq.delete();
            m_eip  = re;
            m_pc   = re & ~32'd3;
            m_skip = re[1:0];
            m_mode = drain ? 2 : 1;
            m_out  = drain;
        end else begin
            if (c) begin
                avail = (mq.size() > 15) ? 15 : mq.size();
                if (m_mode == 1 && avail > 0 && len >= 1 && len <= avail) begin
                    repeat (len) void'(mq.pop_front());
                    m_eip = m_eip + 32'(len);
                end else m_err = 1;
            end
            if (rv && m_out) begin
                if (m_mode == 2) begin
                    m_mode = 1;
                    m_discs++;
                end else begin
                    for (int k = int'(m_skip); k < 4; k++) mq.push_back(d[8*k +: 8]);
                    m_skip = 0;
                end
                m_out = 0;
            end
            if (fire) begin
                m_out = 1;
                m_pc  = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [119:0] eb;
        eb = '0;
        for (int i = 0; i < 15; i++) if (i < mq.size()) eb[8*i +: 8] = mq[i];
        chk($sformatf("rnd%0d.req_valid", cyc), 128'(mem_req_valid), 128'(model_req()));
        chk($sformatf("rnd%0d.req_addr", cyc), 128'(mem_req_addr), 128'(m_pc));
        chk($sformatf("rnd%0d.dec_valid", cyc), 128'(dec_valid), 128'(m_mode == 1 && mq.size() > 0));
        chk($sformatf("rnd%0d.dec_avail", cyc), 128'(dec_avail), 128'((mq.size() > 15) ? 15 : mq.size()));
        chk($sformatf("rnd%0d.dec_eip", cyc), 128'(dec_eip), 128'(m_eip));
        chk($sformatf("rnd%0d.dec_bytes", cyc), 128'(dec_bytes), 128'(eb));
        chk($sformatf("rnd%0d.err", cyc), 128'(underflow_err), 128'(m_err));
    endtask

    initial begin
        vt[0]  = '{1,1,'h1000,1,0,0,0,0,          1,'h1000,0,0,'h1000,0,0};
        vt[1]  = '{1,0,0,1,0,0,0,0,               0,'h1004,0,0,'h1000,0,0};
        vt[2]  = '{1,0,0,1,1,'h44332211,0,0,      1,'h1004,1,4,'h1000,'h44332211,0};
        vt[3]  = '{1,0,0,1,0,0,0,0,               0,'h1008,1,4,'h1000,'h44332211,0};
        vt[4]  = '{1,0,0,0,1,'h88776655,0,0,      1,'h1008,1,8,'h1000,'h44332211,0};
        vt[5]  = '{1,0,0,1,0,0,0,0,               0,'h100C,1,8,'h1000,'h44332211,0};
        vt[6]  = '{1,1,'h3000,1,0,0,0,0,          0,'h3000,0,0,'h3000,0,0};
        vt[7]  = '{1,0,0,1,0,0,0,0,               0,'h3000,0,0,'h3000,0,0};
        vt[8]  = '{1,0,0,1,1,'hDEADBEEF,0,0,      1,'h3000,0,0,'h3000,0,0};
        vt[9]  = '{1,0,0,1,0,0,0,0,               0,'h3004,0,0,'h3000,0,0};
        vt[10] = '{1,0,0,0,1,'h04030201,0,0,      1,'h3004,1,4,'h3000,'h04030201,0};
        vt[11] = '{1,1,'h1003,0,0,0,0,0,          1,'h1000,0,0,'h1003,0,0};
        vt[12] = '{1,0,0,1,0,0,0,0,               0,'h1004,0,0,'h1003,0,0};
        vt[13] = '{1,0,0,0,1,'hDDCCBBAA,0,0,      1,'h1004,1,1,'h1003,'hDD,0};
        vt[14] = '{1,0,0,1,0,0,0,0,               0,'h1008,1,1,'h1003,'hDD,0};
        vt[15] = '{1,0,0,0,1,'h44332211,0,0,      1,'h1008,1,5,'h1003,'h332211DD,0};
        vt[16] = '{1,0,0,0,0,0,1,3,               1,'h1008,1,2,'h1006,'h4433,0};
        vt[17] = '{1,0,0,0,0,0,1,4,               1,'h1008,1,2,'h1006,'h4433,1};
        vt[18] = '{1,1,'h5002,0,0,0,0,0,          1,'h5000,0,0,'h5002,0,1};
        vt[19] = '{0,0,0,0,0,0,0,0,               0,0,0,0,0,0,0};
        vt[20] = '{1,1,'h6000,1,0,0,0,0,          1,'h6000,0,0,'h6000,0,0};
        vt[21] = '{1,0,0,1,0,0,0,0,               0,'h6004,0,0,'h6000,0,0};
        vt[22] = '{1,1,'h7001,0,1,'h11111111,0,0, 1,'h7000,0,0,'h7001,0,0};
        vt[23] = '{1,0,0,1,0,0,0,0,               0,'h7004,0,0,'h7001,0,0};
        vt[24] = '{1,0,0,0,1,'hAABBCCDD,0,0,      1,'h7004,1,3,'h7001,'hAABBCC,0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("reset.req_valid", 128'(mem_req_valid), 0);
        chk("reset.dec_valid", 128'(dec_valid), 0);
        chk("reset.dec_eip", 128'(dec_eip), 0);
        chk("reset.err", 128'(underflow_err), 0);

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].rst_n, vt[i].redir, vt[i].reip, vt[i].rdy, vt[i].rv, vt[i].data,
                  vt[i].cons, vt[i].len);
            tick();
            chk($sformatf("vec%0d.req_valid", i), 128'(mem_req_valid), 128'(vt[i].e_req));
            chk($sformatf("vec%0d.req_addr", i), 128'(mem_req_addr), 128'(vt[i].e_addr));
            chk($sformatf("vec%0d.dec_valid", i), 128'(dec_valid), 128'(vt[i].e_dv));
            chk($sformatf("vec%0d.dec_avail", i), 128'(dec_avail), 128'(vt[i].e_avail));
            chk($sformatf("vec%0d.dec_eip", i), 128'(dec_eip), 128'(vt[i].e_eip));
            chk($sformatf("vec%0d.bytes_lo", i), 128'(dec_bytes[31:0]), 128'(vt[i].e_b0));
            chk($sformatf("vec%0d.err", i), 128'(underflow_err), 128'(vt[i].e_err));
        end

        // consume and response in the same cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 'h2000, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 'h03020100, 0, 0); tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 'h07060504, 0, 0); tick();
        chk("cr.avail8", 128'(dec_avail), 8);
        drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 'h0B0A0908, 1, 3); tick();
        chk("cr.avail", 128'(dec_avail), 9);
        chk("cr.eip", 128'(dec_eip), 'h2003);
        chk("cr.err", 128'(underflow_err), 0);
        chk("cr.bytes_lo", 128'(dec_bytes[31:0]), 'h06050403);
        chk("cr.byte8", 128'(dec_bytes[71:64]), 'h0B);
        chk("cr.byte9", 128'(dec_bytes[79:72]), 0);

        // fill to 13 bytes: no request while free space is 3
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 'h3, 0, 0, 0, 0, 0); tick();
        for (int w = 0; w < 4; w++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
            drive(1, 0, 0, 0, 1, 32'h01010101 * (w + 1), 0, 0); tick();
        end
        chk("full.avail", 128'(dec_avail), 13);
        chk("full.req_valid", 128'(mem_req_valid), 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
        chk("full.req_valid_rdy", 128'(mem_req_valid), 0);
        drive(1, 0, 0, 0, 0, 0, 1, 5); tick();
        chk("full.req_after_consume", 128'(mem_req_valid), 1);
        chk("full.addr", 128'(mem_req_addr), 'h10);
        chk("full.eip", 128'(dec_eip), 'h8);
        chk("full.avail_after", 128'(dec_avail), 8);

        // randomized traffic against the reference model
        begin
            bit          pend, fire;
            int          wait_c;
            logic [31:0] pend_data, re;
            logic        r, rd, rdy, rv, c;
            logic [3:0]  len;
            pend = 0; wait_c = 0; pend_data = 0;
            drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
            model_reset();
            for (int cyc = 0; cyc < 4000; cyc++) begin
                r   = ($urandom_range(0, 499) != 0);
                rd  = ($urandom_range(0, 29) == 0);
                re  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
                rdy = ($urandom_range(0, 2) != 0);
                rv  = pend && (wait_c == 0);
                c   = ($urandom_range(0, 2) == 0);
                if (dec_avail != 0 && $urandom_range(0, 7) != 0) len = 4'($urandom_range(1, dec_avail));
                else len = 4'($urandom_range(0, 15));
                fire = mem_req_valid && rdy;
                drive(r, rd, re, rdy, rv, pend_data, c, len);
                tick();
                if (!r) pend = 0;
                else begin
                    if (rv) pend = 0;
                    if (pend && wait_c > 0) wait_c--;
                    if (fire) begin
                        pend = 1;
                        wait_c = $urandom_range(0, 2);
                        pend_data = $urandom;
                    end
                end
                model_step(r, rd, re, rdy, rv, pend_data_sel(rv, mem_rsp_data), c, int'(len));
                model_compare(cyc);
            end
`ifdef IFETCH_STATS_EN
            chk("stats.redirects", 128'(stat_redirects), 128'(m_redirs));
            chk("stats.discards", 128'(stat_discards), 128'(m_discs));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // The response data actually presented in the cycle is what the model appends.
    function automatic logic [31:0] pend_data_sel(input logic rv, input logic [31:0] d);
        return rv ? d : 32'd0;
    endfunction

endmodule
